// File: rtl/pmic_mon_pkg.sv
// Shared constants and types for the OV/UV monitor flag filtering.
package pmic_mon_pkg;

  // Default filter lengths in main_clk20m cycles (5/10/20/40 us at 20 MHz)
  localparam int unsigned THR0_DEF = 100;
  localparam int unsigned THR1_DEF = 200;
  localparam int unsigned THR2_DEF = 400;
  localparam int unsigned THR3_DEF = 800;

  typedef int unsigned filt_thr_t [4];

  localparam filt_thr_t FILT_THR_DEF = '{THR0_DEF, THR1_DEF, THR2_DEF, THR3_DEF};

  typedef enum logic [1:0] {
    FILT_SEL_5US  = 2'd0,
    FILT_SEL_10US = 2'd1,
    FILT_SEL_20US = 2'd2,
    FILT_SEL_40US = 2'd3
  } filt_sel_e;

  // Channel positions in the raw_flt / flt_* vectors
  localparam int unsigned CH_VMON_OV0    = 0;
  localparam int unsigned CH_VMON_OV1    = 1;
  localparam int unsigned CH_VMON_OV2    = 2;
  localparam int unsigned CH_VMON_OV3    = 3;
  localparam int unsigned CH_VMON_UV0    = 4;
  localparam int unsigned CH_VMON_UV1    = 5;
  localparam int unsigned CH_VMON_UV2    = 6;
  localparam int unsigned CH_VMON_UV3    = 7;
  localparam int unsigned CH_VCOREMON_OV = 8;
  localparam int unsigned CH_VCOREMON_UV = 9;
  localparam int unsigned CH_VDDIO_OV    = 10;
  localparam int unsigned CH_VDDIO_UV    = 11;

endpackage

// File: rtl/mon_flt_ch.sv
// One monitor channel: raw flag synchronizer plus symmetric deglitch counter.
module mon_flt_ch
  import pmic_mon_pkg::*;
#(
  parameter int unsigned SYNC_STG = 2,
  parameter int unsigned CNT_W    = 10,
  parameter filt_thr_t   THR      = FILT_THR_DEF
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_raw,
  input  logic       i_en,
  input  logic [1:0] i_sel,
  output logic       o_sts
);

  logic [SYNC_STG-1:0] r_sync;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_sts;
  logic                w_s;
  filt_sel_e           w_sel;
  logic [CNT_W-1:0]    w_thr_m1;

  assign w_s   = r_sync[SYNC_STG-1];
  assign w_sel = filt_sel_e'(i_sel);
  assign o_sts = r_sts;

  // Terminal count for the currently selected filter length
  always_comb begin
    w_thr_m1 = CNT_W'(THR[0] - 1);
    case (w_sel)
      FILT_SEL_5US:  w_thr_m1 = CNT_W'(THR[0] - 1);
      FILT_SEL_10US: w_thr_m1 = CNT_W'(THR[1] - 1);
      FILT_SEL_20US: w_thr_m1 = CNT_W'(THR[2] - 1);
      FILT_SEL_40US: w_thr_m1 = CNT_W'(THR[3] - 1);
      default:       w_thr_m1 = CNT_W'(THR[0] - 1);
    endcase
  end

  // Multi-flop synchronizer for the asynchronous comparator flag
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STG-2:0], i_raw};
    end
  end

  // Deglitch counter: status follows the flag after thr consecutive mismatches.
  // The >= compare lets a shortened threshold take effect without wrapping.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
      r_sts <= 1'b0;
    end else if (!i_en) begin
      r_cnt <= '0;
      r_sts <= 1'b0;
    end else if (w_s == r_sts) begin
      r_cnt <= '0;
    end else if (r_cnt >= w_thr_m1) begin
      r_sts <= w_s;
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/mon_flt_deglitch.sv
// Deglitch filter, sticky fault latch and interrupt pulse for the OV/UV flags.
module mon_flt_deglitch
  import pmic_mon_pkg::*;
#(
  parameter int unsigned CH       = 12,
  parameter int unsigned SYNC_STG = 2,
  parameter int unsigned CNT_W    = 10,
  parameter int unsigned THR0     = THR0_DEF,
  parameter int unsigned THR1     = THR1_DEF,
  parameter int unsigned THR2     = THR2_DEF,
  parameter int unsigned THR3     = THR3_DEF
) (
  input  logic              main_clk20m,
  input  logic              dig_rst,
  input  logic [CH-1:0]     raw_flt,
  input  logic [CH-1:0]     mon_en,
  input  logic [2*CH-1:0]   filt_sel,
  input  logic [CH-1:0]     int_mask,
  input  logic              clr_pulse,
  input  logic [CH-1:0]     clr_mask,
  output logic [CH-1:0]     flt_sts,
  output logic [CH-1:0]     flt_lat,
  output logic              flt_int,
  output logic              flt_any
);

  localparam filt_thr_t THR = '{THR0, THR1, THR2, THR3};

  logic [CH-1:0] r_sts_prev;
  logic [CH-1:0] w_set;
  logic [CH-1:0] w_clr;

  for (genvar gi = 0; gi < CH; gi++) begin : g_ch
    mon_flt_ch #(
      .SYNC_STG (SYNC_STG),
      .CNT_W    (CNT_W),
      .THR      (THR)
    ) u_ch (
      .i_clk (main_clk20m),
      .i_rst (dig_rst),
      .i_raw (raw_flt[gi]),
      .i_en  (mon_en[gi]),
      .i_sel (filt_sel[2*gi +: 2]),
      .o_sts (flt_sts[gi])
    );
  end

  // Rising edge of filtered status; a disabled channel can never set its latch
  assign w_set = flt_sts & ~r_sts_prev & mon_en;
  assign w_clr = {CH{clr_pulse}} & clr_mask;

  // Sticky latch (set beats clear), interrupt pulse and summary flag
  always_ff @(posedge main_clk20m or posedge dig_rst) begin
    if (dig_rst) begin
      r_sts_prev <= '0;
      flt_lat    <= '0;
      flt_int    <= 1'b0;
      flt_any    <= 1'b0;
    end else begin
      r_sts_prev <= flt_sts;
      flt_lat    <= w_set | (flt_lat & ~w_clr);
      flt_int    <= |(w_set & ~int_mask);
      flt_any    <= |(flt_sts & mon_en);
    end
  end

endmodule

// File: tb/tb_mon_flt_deglitch.sv
module tb_mon_flt_deglitch;

  localparam int CH   = 12;
  localparam int SYNC = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [CH-1:0]   raw;
  logic [CH-1:0]   en;
  logic [2*CH-1:0] sel;
  logic [CH-1:0]   imask;
  logic            clr;
  logic [CH-1:0]   cmask;
  logic [CH-1:0]   flt_sts;
  logic [CH-1:0]   flt_lat;
  logic            flt_int;
  logic            flt_any;

  int errors = 0;
  int checks = 0;

  // Reference model state: delay line of sampled raw vectors, mismatch run lengths
  logic [CH-1:0] m_hist [$];
  int            m_run [CH];
  logic [CH-1:0] m_sts, m_prev, m_lat;
  logic          m_int, m_any;

  always #5 clk = ~clk;

  mon_flt_deglitch #(
    .CH       (CH),
    .SYNC_STG (SYNC),
    .CNT_W    (10),
    .THR0     (100),
    .THR1     (200),
    .THR2     (400),
    .THR3     (800)
  ) dut (
    .main_clk20m (clk),
    .dig_rst     (rst),
    .raw_flt     (raw),
    .mon_en      (en),
    .filt_sel    (sel),
    .int_mask    (imask),
    .clr_pulse   (clr),
    .clr_mask    (cmask),
    .flt_sts     (flt_sts),
    .flt_lat     (flt_lat),
    .flt_int     (flt_int),
    .flt_any     (flt_any)
  );

  function automatic int thr_of(input logic [1:0] s);
    case (s)
      2'd0:    return 100;
      2'd1:    return 200;
      2'd2:    return 400;
      default: return 800;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_hist.delete();
    repeat (SYNC) m_hist.push_back('0);
    for (int i = 0; i < CH; i++) m_run[i] = 0;
    m_sts  = '0;
    m_prev = '0;
    m_lat  = '0;
    m_int  = 1'b0;
    m_any  = 1'b0;
  endtask

  // One clock of the specified behaviour, computed from pre-edge values
  task automatic model_edge();
    logic [CH-1:0] s, set, n_sts;
    if (rst) begin
      model_reset();
      return;
    end
    s = m_hist.pop_front();
    m_hist.push_back(raw);
    set   = m_sts & ~m_prev & en;
    n_sts = m_sts;
    for (int i = 0; i < CH; i++) begin
      if (!en[i]) begin
        m_run[i] = 0;
        n_sts[i] = 1'b0;
      end else if (s[i] != m_sts[i]) begin
        if (m_run[i] + 1 >= thr_of(sel[2*i +: 2])) begin
          n_sts[i] = s[i];
          m_run[i] = 0;
        end else begin
          m_run[i] = m_run[i] + 1;
        end
      end else begin
        m_run[i] = 0;
      end
    end
    m_lat  = set | (m_lat & ~({CH{clr}} & cmask));
    m_int  = |(set & ~imask);
    m_any  = |(m_sts & en);
    m_prev = m_sts;
    m_sts  = n_sts;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("flt_sts", 32'(flt_sts), 32'(m_sts));
    chk("flt_lat", 32'(flt_lat), 32'(m_lat));
    chk("flt_int", 32'(flt_int), 32'(m_int));
    chk("flt_any", 32'(flt_any), 32'(m_any));
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic clear_all();
    clr = 1'b1; cmask = '1;
    step();
    clr = 1'b0; cmask = '0;
  endtask

  initial begin
    int n, cnt, pulses;
    logic saw;

    // Reset with all raw flags active
    raw = '1; en = '1; sel = '0; imask = '0; clr = 1'b0; cmask = '0;
    model_reset();
    #2 rst = 1'b1;
    run(3);
    chk("rst_sts", 32'(flt_sts), 32'h0);
    chk("rst_lat", 32'(flt_lat), 32'h0);
    chk("rst_int", 32'(flt_int), 32'h0);
    rst = 1'b0;
    n = 0;
    while (flt_sts[0] !== 1'b1 && n < 200) begin
      step();
      n++;
    end
    chk("rise_latency_in_102_103", 32'(n >= 102 && n <= 103), 32'h1);

    raw = '0;
    run(300);
    clear_all();
    chk("cleared_all", 32'(flt_lat), 32'h0);

    // Glitch reject on ch3 with 200-clock filter
    sel[7:6] = 2'd1;
    raw[3] = 1'b1;
    saw = 1'b0;
    repeat (199) begin step(); saw |= flt_sts[3] | flt_int; end
    raw[3] = 1'b0;
    repeat (250) begin step(); saw |= flt_sts[3] | flt_int; end
    chk("glitch199_rejected", 32'(saw), 32'h0);
    raw[3] = 1'b1;
    cnt = 0;
    repeat (200) begin step(); cnt += int'(flt_sts[3]); end
    raw[3] = 1'b0;
    repeat (600) begin step(); cnt += int'(flt_sts[3]); end
    chk("pulse200_width", 32'(cnt), 32'd200);
    sel[7:6] = 2'd0;

    // Set/clear race on ch5, then clear while still faulted
    raw[5] = 1'b1;
    n = 0;
    while (flt_sts[5] !== 1'b1 && n < 300) begin step(); n++; end
    chk("ch5_rose", 32'(flt_sts[5]), 32'h1);
    clr = 1'b1; cmask = CH'(1) << 5;
    step();
    clr = 1'b0; cmask = '0;
    chk("race_set_wins", 32'(flt_lat[5]), 32'h1);
    run(20);
    clr = 1'b1; cmask = CH'(1) << 5;
    step();
    clr = 1'b0; cmask = '0;
    chk("clear_while_faulted", 32'(flt_lat[5]), 32'h0);
    run(50);
    chk("no_reset_without_edge", 32'(flt_lat[5]), 32'h0);
    raw[5] = 1'b0;
    run(250);

    // Interrupt: ch1 and ch7 together, ch7 masked
    clear_all();
    imask[7] = 1'b1;
    raw[1] = 1'b1; raw[7] = 1'b1;
    pulses = 0;
    repeat (150) begin step(); pulses += int'(flt_int); end
    chk("one_int_pulse", 32'(pulses), 32'd1);
    chk("lat1_lat7", 32'({flt_lat[1], flt_lat[7]}), 32'h3);
    raw[1] = 1'b0; raw[7] = 1'b0;
    run(250);
    clear_all();
    imask[1] = 1'b1;
    raw[1] = 1'b1; raw[7] = 1'b1;
    pulses = 0;
    repeat (150) begin step(); pulses += int'(flt_int); end
    chk("masked_no_pulse", 32'(pulses), 32'd0);
    chk("masked_lat1_lat7", 32'({flt_lat[1], flt_lat[7]}), 32'h3);
    raw[1] = 1'b0; raw[7] = 1'b0;
    run(250);
    imask = '0;
    clear_all();

    // Threshold shortened mid-count on ch2
    sel[5:4] = 2'd3;
    raw[2] = 1'b1;
    run(302);
    chk("thr3_not_yet", 32'(flt_sts[2]), 32'h0);
    sel[5:4] = 2'd1;
    step();
    chk("thr_switch_flip", 32'(flt_sts[2]), 32'h1);
    sel[5:4] = 2'd0;
    raw[2] = 1'b0;
    run(300);

    // Disable ch9 after a latched fault
    raw[9] = 1'b1;
    run(110);
    chk("ch9_latched", 32'(flt_lat[9]), 32'h1);
    en[9] = 1'b0;
    step();
    chk("ch9_sts_off", 32'(flt_sts[9]), 32'h0);
    chk("ch9_lat_kept", 32'(flt_lat[9]), 32'h1);
    repeat (15) begin raw[9] = ~raw[9]; run(20); end
    chk("ch9_lat_still", 32'(flt_lat[9]), 32'h1);
    clr = 1'b1; cmask = CH'(1) << 9;
    step();
    clr = 1'b0; cmask = '0;
    raw[9] = 1'b1;
    run(250);
    chk("ch9_no_new_set", 32'(flt_lat[9]), 32'h0);
    raw[9] = 1'b0;
    en[9] = 1'b1;
    run(10);

    // Asynchronous reset in the middle of counting
    raw[10] = 1'b1;
    run(150);
    raw[4] = 1'b1; raw[6] = 1'b1;
    run(50);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_sts", 32'(flt_sts), 32'h0);
    chk("async_rst_lat", 32'(flt_lat), 32'h0);
    chk("async_rst_any", 32'(flt_any), 32'h0);
    model_reset();
    step();
    rst = 1'b0;
    raw = '0;
    run(20);

    // Randomized traffic against the reference model
    for (int c = 0; c < 15000; c++) begin
      for (int i = 0; i < CH; i++)
        if ($urandom_range(0, 119) == 0) raw[i] = ~raw[i];
      if ($urandom_range(0, 39) == 0) begin
        clr = 1'b1; cmask = CH'($urandom);
      end else begin
        clr = 1'b0; cmask = '0;
      end
      if ($urandom_range(0, 499) == 0) imask = CH'($urandom);
      if ($urandom_range(0, 999) == 0) begin
        n = int'($urandom_range(0, CH - 1));
        en[n] = ~en[n];
      end
      if ($urandom_range(0, 299) == 0) begin
        n = int'($urandom_range(0, CH - 1));
        sel[2*n +: 2] = 2'($urandom_range(0, 1));
      end
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
